rotor_stepper: RTL and testbench

ROTOR_STEPPER -- requirements
Module: rotor_stepper

---
 rtl/rotor_stepper.sv | 130 +++++++++++++
 tb/tb_rotor_stepper.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rotor_stepper.sv
// Rotor stepping unit: odometer-style rotor positions advanced one key at a time.
// Define ROTOR_DOUBLE_STEP_EN to add the middle-rotor double-step anomaly.
module rotor_stepper #(
   parameter int NUM_ROTORS = 3,
   parameter int ALPHA      = 26,
   parameter int POS_W      = 6
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        key_valid,
   output logic                        key_ready,
   input  logic                        load,
   input  logic [NUM_ROTORS*POS_W-1:0] load_pos,
   input  logic [NUM_ROTORS*POS_W-1:0] notch_pos,
   output logic [NUM_ROTORS*POS_W-1:0] rotor_pos,
   output logic                        pos_valid,
   output logic                        wrap
);

   typedef enum logic {IDLE, DONE} state_t;

   localparam logic [POS_W-1:0] LAST_POS = POS_W'(ALPHA - 1);
   localparam logic [POS_W:0]   ALPHA_W  = (POS_W + 1)'(ALPHA);

   state_t           state_q, state_d;
   logic [1:0]       rst_sync_q;
   logic [POS_W-1:0] pos_q [NUM_ROTORS];
   logic [POS_W-1:0] pos_d [NUM_ROTORS];
   logic [POS_W-1:0] load_fld [NUM_ROTORS];
   logic             wrap_q, wrap_d;

   logic [NUM_ROTORS-1:0] match;
   logic [NUM_ROTORS-1:0] step;
   logic                  key_accept;
   logic                  unused_last_match;

   // Keys are refused until the deasserted reset has crossed both sync stages.
   assign key_ready  = (state_q == IDLE) && (rst_sync_q[1] || !rst);
   assign key_accept = key_valid && (state_q == IDLE) && rst_sync_q[1];
   assign pos_valid  = (state_q == DONE);
   assign wrap       = wrap_q;

   // The last rotor has nothing to carry into.
   assign unused_last_match = match[NUM_ROTORS-1];

   generate
      for (genvar gi = 0; gi < NUM_ROTORS; gi++) begin : g_rotor
         logic [POS_W-1:0] notch_fld;
         logic [POS_W-1:0] load_raw;

         assign notch_fld = notch_pos[gi*POS_W +: POS_W];
         assign load_raw  = load_pos[gi*POS_W +: POS_W];

         // An out-of-range notch can never be reached, so it never carries.
         assign match[gi] = (pos_q[gi] == notch_fld) && ({1'b0, notch_fld} < ALPHA_W);

         assign load_fld[gi] = ({1'b0, load_raw} < ALPHA_W) ? load_raw : '0;
         assign rotor_pos[gi*POS_W +: POS_W] = pos_q[gi];

         if (gi == 0) begin : g_first
            assign step[gi] = key_accept;
         end else begin : g_carry
`ifdef ROTOR_DOUBLE_STEP_EN
            if (gi <= NUM_ROTORS - 2) begin : g_double
               // A middle rotor sitting on its own notch steps itself and its neighbour.
               assign step[gi] = (step[gi-1] && match[gi-1]) || (key_accept && match[gi]);
            end else begin : g_plain
               assign step[gi] = step[gi-1] && match[gi-1];
            end
`else
            assign step[gi] = step[gi-1] && match[gi-1];
`endif
         end
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      wrap_d  = 1'b0;
      for (int i = 0; i < NUM_ROTORS; i++) begin
         pos_d[i] = pos_q[i];
      end

      if (load) begin
         state_d = IDLE;
         for (int i = 0; i < NUM_ROTORS; i++) begin
            pos_d[i] = load_fld[i];
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (key_accept) begin
                  state_d = DONE;
                  for (int i = 0; i < NUM_ROTORS; i++) begin
                     if (step[i]) begin
                        pos_d[i] = (pos_q[i] == LAST_POS) ? '0 : pos_q[i] + POS_W'(1);
                     end
                  end
                  wrap_d = step[NUM_ROTORS-1] && (pos_q[NUM_ROTORS-1] == LAST_POS);
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         wrap_q     <= 1'b0;
         rst_sync_q <= 2'b00;
         for (int i = 0; i < NUM_ROTORS; i++) begin
            pos_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         wrap_q     <= wrap_d;
         rst_sync_q <= {rst_sync_q[0], 1'b1};
         for (int i = 0; i < NUM_ROTORS; i++) begin
            pos_q[i] <= pos_d[i];
         end
      end
   end

endmodule

// File: tb/tb_rotor_stepper.sv
// Scoreboard bench for rotor_stepper (3 rotors, alphabet 26); expected positions
// are queued when a key is accepted and compared when pos_valid pulses.
module tb_rotor_stepper;

   localparam int NR = 3;
   localparam int AL = 26;
   localparam int PW = 6;

   typedef struct packed {
      logic [NR*PW-1:0] pos;
      logic             wrap;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             key_valid;
   logic             key_ready;
   logic             load;
   logic [NR*PW-1:0] load_pos;
   logic [NR*PW-1:0] notch_pos;
   logic [NR*PW-1:0] rotor_pos;
   logic             pos_valid;
   logic             wrap;

   int   n_checks = 0;
   int   n_errors = 0;
   int   mpos [NR];
   exp_t exp_q [$];
   exp_t mon_e;
   logic [NR*PW-1:0] e35 [3];

   rotor_stepper #(.NUM_ROTORS(NR), .ALPHA(AL), .POS_W(PW)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .load      (load),
      .load_pos  (load_pos),
      .notch_pos (notch_pos),
      .rotor_pos (rotor_pos),
      .pos_valid (pos_valid),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   function automatic logic [NR*PW-1:0] pk(input int a2, input int a1, input int a0);
      return {PW'(a2), PW'(a1), PW'(a0)};
   endfunction

   function automatic bit hit(input int i);
      int f;
      f = int'(notch_pos[i*PW +: PW]);
      return (f < AL) && (mpos[i] == f);
   endfunction

   // Reference stepping: rotor 0 always, carry on notch, optional middle double step.
   function automatic void model_key();
      bit st [NR];
      bit w;
      st[0] = 1'b1;
      for (int i = 1; i < NR; i++) begin
         st[i] = st[i-1] && hit(i-1);
`ifdef ROTOR_DOUBLE_STEP_EN
         if (i <= NR - 2 && hit(i)) st[i] = 1'b1;
`endif
      end
      w = st[NR-1] && (mpos[NR-1] == AL - 1);
      for (int i = 0; i < NR; i++) begin
         if (st[i]) mpos[i] = (mpos[i] + 1) % AL;
      end
      exp_q.push_back(exp_t'({pk(mpos[2], mpos[1], mpos[0]), w}));
   endfunction

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (pos_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_pos_valid", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("sb_rotor_pos", 32'(rotor_pos), 32'(mon_e.pos));
               check_eq("sb_wrap", 32'(wrap), 32'(mon_e.wrap));
               $display("key done: rotor_pos=%0d,%0d,%0d wrap=%0b", rotor_pos[17:12],
                        rotor_pos[11:6], rotor_pos[5:0], wrap);
            end
         end else if (wrap !== 1'b0) begin
            check_eq("wrap_without_pos_valid", 32'(wrap), 32'd0);
         end
      end
   end

   // Entered and left right after a falling edge.
   task automatic send_key();
      int guard = 0;
      key_valid = 1'b1;
      while (key_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (key_ready !== 1'b1) begin
         check_eq("key_ready_timeout", 32'(key_ready), 32'd1);
         key_valid = 1'b0;
      end else begin
         model_key();
         @(posedge clk);
         #1 key_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic do_load(input logic [NR*PW-1:0] v);
      int f;
      load     = 1'b1;
      load_pos = v;
      @(posedge clk);
      #1 load = 1'b0;
      for (int i = 0; i < NR; i++) begin
         f = int'(v[i*PW +: PW]);
         mpos[i] = (f < AL) ? f : 0;
      end
      @(negedge clk);
      check_eq("load_rotor_pos", 32'(rotor_pos), 32'(pk(mpos[2], mpos[1], mpos[0])));
      check_eq("load_no_pos_valid", 32'(pos_valid), 32'd0);
      $display("load: rotor_pos=%0d,%0d,%0d", rotor_pos[17:12], rotor_pos[11:6], rotor_pos[5:0]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      key_valid = 1'b0;
      load      = 1'b0;
      load_pos  = '0;
      notch_pos = pk(21, 4, 16);
      for (int i = 0; i < NR; i++) mpos[i] = 0;
`ifdef ROTOR_DOUBLE_STEP_EN
      e35[0] = pk(0, 4, 17); e35[1] = pk(1, 5, 18); e35[2] = pk(1, 5, 19);
`else
      e35[0] = pk(0, 4, 17); e35[1] = pk(0, 4, 18); e35[2] = pk(0, 4, 19);
`endif

      // Reset state.
      #2 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_rotor_pos", 32'(rotor_pos), 32'd0);
      check_eq("rst_key_ready", 32'(key_ready), 32'd1);
      check_eq("rst_pos_valid", 32'(pos_valid), 32'd0);
      check_eq("rst_wrap", 32'(wrap), 32'd0);
      repeat (2) @(negedge clk);

      // A key held across the first edge after deassertion is not taken.
      rst       = 1'b1;
      key_valid = 1'b1;
      @(negedge clk);
      check_eq("sync_no_accept_pv", 32'(pos_valid), 32'd0);
      check_eq("sync_no_accept_pos", 32'(rotor_pos), 32'd0);
      key_valid = 1'b0;
      repeat (3) @(negedge clk);

      // 26 keys: rotor 0 cycles fully, rotor 1 steps once at rotor 0 = 16.
      for (int k = 1; k <= 26; k++) begin
         send_key();
         if (k == 16) check_eq("r1_before_notch", 32'(rotor_pos[11:6]), 32'd0);
         if (k == 17) check_eq("r1_after_notch", 32'(rotor_pos[11:6]), 32'd1);
      end
      check_eq("odometer_26", 32'(rotor_pos), 32'(pk(0, 1, 0)));

      // Carry through two wrapping rotors.
      notch_pos = pk(0, 25, 25);
      do_load(pk(0, 25, 25));
      send_key();
      check_eq("carry_chain", 32'(rotor_pos), 32'(pk(1, 0, 0)));
      check_eq("carry_chain_wrap", 32'(wrap), 32'd0);

      // Last rotor wraps.
      notch_pos = pk(25, 25, 25);
      do_load(pk(25, 25, 25));
      send_key();
      check_eq("full_wrap_pos", 32'(rotor_pos), 32'(pk(0, 0, 0)));
      check_eq("full_wrap_pulse", 32'({wrap, pos_valid}), 32'd3);
      @(negedge clk);
      check_eq("full_wrap_one_cycle", 32'(wrap), 32'd0);

      // Double-step scenario.
      notch_pos = pk(21, 4, 16);
      do_load(pk(0, 3, 16));
      for (int k = 0; k < 3; k++) begin
         send_key();
         check_eq($sformatf("double_step_%0d", k), 32'(rotor_pos), 32'(e35[k]));
      end

      // key_valid held high: one key every second cycle.
      do_load(pk(0, 0, 0));
      key_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         check_eq($sformatf("stream_ready_%0d", c), 32'(key_ready), 32'((c % 2) == 0));
         check_eq($sformatf("stream_pv_%0d", c), 32'(pos_valid), 32'((c % 2) == 1));
         if (key_ready === 1'b1) model_key();
         @(negedge clk);
      end
      key_valid = 1'b0;

      // Load and key in the same cycle: load wins.
      key_valid = 1'b1;
      load      = 1'b1;
      load_pos  = pk(2, 3, 4);
      @(posedge clk);
      #1 key_valid = 1'b0;
      load = 1'b0;
      mpos[2] = 2; mpos[1] = 3; mpos[0] = 4;
      @(negedge clk);
      check_eq("load_beats_key_pos", 32'(rotor_pos), 32'(pk(2, 3, 4)));
      check_eq("load_beats_key_pv", 32'(pos_valid), 32'd0);
      @(negedge clk);
      check_eq("load_beats_key_pv2", 32'(pos_valid), 32'd0);

      // Out-of-range load field becomes 0.
      do_load(pk(30, 5, 7));
      check_eq("load_clamp", 32'(rotor_pos), 32'(pk(0, 5, 7)));

      // Reset in the middle of DONE.
      send_key();
      #2 rst = 1'b0;
      #1;
      check_eq("midrst_pos", 32'(rotor_pos), 32'd0);
      check_eq("midrst_pv", 32'(pos_valid), 32'd0);
      check_eq("midrst_wrap", 32'(wrap), 32'd0);
      check_eq("midrst_ready", 32'(key_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < NR; i++) mpos[i] = 0;
      repeat (4) @(negedge clk);
      send_key();
      check_eq("post_rst_key", 32'(rotor_pos), 32'(pk(0, 0, 1)));

      repeat (3) @(negedge clk);
      check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
